// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad lock: controller state encoding, default key codes
// and the digit key range that the controller and the digit accumulator both use.
package keylock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_SET     = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic [7:0] DEF_ENTER_KEY = 8'd10;
    localparam logic [7:0] DEF_CLEAR_KEY = 8'd11;
    localparam logic [7:0] DEF_PROG_KEY  = 8'd12;

    // Keys in this range are the only ones the accumulator turns into digits.
    localparam logic [7:0] DIGIT_MIN = 8'd1;
    localparam logic [7:0] DIGIT_MAX = 8'd6;

    localparam int TIMER_W = 28;
    localparam int CNT_W   = 4;

    function automatic logic is_digit_key(input logic [7:0] k);
        return (k >= DIGIT_MIN) && (k <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/keylock_ctrl_key_edge_detect.sv
// Turns the level-sensitive button_pressed into a single-cycle press qualifier,
// plus a digit qualifier for presses of keys in the accumulator's digit range.
module key_edge_detect
    import keylock_pkg::*;
(
    input  logic       hwclk,
    input  logic       reset,
    input  logic [7:0] i_key,
    input  logic       i_button_pressed,
    output logic       o_press,
    output logic       o_digit
);

    logic r_btn_q;

    // NOTE: non-blocking, so o_press compares against last cycle's level, not this one.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= i_button_pressed;
        end
    end

    assign o_press = i_button_pressed & ~r_btn_q;
    assign o_digit = o_press & is_digit_key(i_key);

endmodule

// File: rtl/keylock_ctrl.sv
// Keypad lock sequencer: drives the digit accumulator's enable, checks the entered code,
// grants timed unlock, locks out after repeated failures and allows re-programming.
module keylock_ctrl
    import keylock_pkg::*;
#(
    parameter logic [31:0] CODE_INIT      = 32'd1234,
    parameter int          CODE_DIGITS    = 4,
    parameter int          MAX_ATTEMPTS   = 3,
    parameter logic [23:0] UNLOCK_CYCLES  = 24'd12_000_000,
    parameter logic [27:0] LOCKOUT_CYCLES = 28'd120_000_000,
    parameter logic [7:0]  ENTER_KEY      = DEF_ENTER_KEY,
    parameter logic [7:0]  CLEAR_KEY      = DEF_CLEAR_KEY,
    parameter logic [7:0]  PROG_KEY       = DEF_PROG_KEY
) (
    input  logic        hwclk,
    input  logic        reset,
    input  logic [7:0]  key,
    input  logic        button_pressed,
    input  logic [31:0] typed,
    output logic        entry_enable,
    output logic        unlocked,
    output logic        lockout,
    output logic        fail_pulse,
    output logic [3:0]  attempts_left,
    output logic        prog_mode
);

    localparam logic [CNT_W-1:0]   L_CODE_DIGITS  = 4'(CODE_DIGITS);
    localparam logic [CNT_W-1:0]   L_MAX_ATTEMPTS = 4'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] L_UNLOCK_LOAD  = {4'd0, UNLOCK_CYCLES} - 28'd1;
    localparam logic [TIMER_W-1:0] L_LOCKOUT_LOAD = LOCKOUT_CYCLES - 28'd1;

    state_t             r_state;
    logic               r_entry_enable;
    logic               r_unlocked;
    logic               r_lockout;
    logic               r_fail_pulse;
    logic [CNT_W-1:0]   r_attempts;
    logic               r_prog_mode;
    logic [31:0]        r_code;
    logic [TIMER_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_digit_cnt;

    logic w_press;
    logic w_digit;
    logic w_enter;
    logic w_clear;
    logic w_prog;
    logic w_count_ok;
    logic w_match;

    key_edge_detect u_key_edge_detect (
        .hwclk            (hwclk),
        .reset            (reset),
        .i_key            (key),
        .i_button_pressed (button_pressed),
        .o_press          (w_press),
        .o_digit          (w_digit)
    );

    assign w_enter    = w_press && (key == ENTER_KEY);
    assign w_clear    = w_press && (key == CLEAR_KEY);
    assign w_prog     = w_press && (key == PROG_KEY);
    assign w_count_ok = (r_digit_cnt == L_CODE_DIGITS);
    assign w_match    = (typed == r_code) && w_count_ok;

    // Tracks how many digits the accumulator has absorbed; it restarts with it.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_digit_cnt <= '0;
        end else if (!r_entry_enable) begin
            r_digit_cnt <= '0;
        end else if (w_digit && (r_state == ST_ENTRY || r_state == ST_SET)
                     && (r_digit_cnt != 4'hF)) begin
            r_digit_cnt <= r_digit_cnt + 4'd1;
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            r_state        <= ST_ENTRY;
            r_entry_enable <= 1'b0;
            r_unlocked     <= 1'b0;
            r_lockout      <= 1'b0;
            r_fail_pulse   <= 1'b0;
            r_attempts     <= L_MAX_ATTEMPTS;
            r_prog_mode    <= 1'b0;
            // NOTE: the stored code is an ordinary register, so reset restores CODE_INIT.
            r_code         <= CODE_INIT;
            r_timer        <= '0;
        end else begin
            r_fail_pulse <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (w_enter) begin
                        r_state        <= ST_CHECK;
                        r_entry_enable <= 1'b0;
                    end else if (w_clear) begin
                        r_entry_enable <= 1'b0;
                    end else begin
                        r_entry_enable <= 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (w_match) begin
                        r_state    <= ST_OPEN;
                        r_unlocked <= 1'b1;
                        r_attempts <= L_MAX_ATTEMPTS;
                        r_timer    <= L_UNLOCK_LOAD;
                    end else if (r_attempts > 4'd1) begin
                        // The CHECK cycle already held enable low, so re-entry starts clean.
                        r_state        <= ST_ENTRY;
                        r_entry_enable <= 1'b1;
                        r_attempts     <= r_attempts - 4'd1;
                        r_fail_pulse   <= 1'b1;
                    end else begin
                        r_state      <= ST_LOCKOUT;
                        r_lockout    <= 1'b1;
                        r_attempts   <= '0;
                        r_fail_pulse <= 1'b1;
                        r_timer      <= L_LOCKOUT_LOAD;
                    end
                end

                ST_OPEN: begin
                    if (w_clear || (!w_prog && r_timer == '0)) begin
                        r_state        <= ST_ENTRY;
                        r_unlocked     <= 1'b0;
                        r_entry_enable <= 1'b0;
                    end else if (w_prog) begin
                        r_state        <= ST_SET;
                        r_prog_mode    <= 1'b1;
                        r_entry_enable <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 28'd1;
                    end
                end

                ST_SET: begin
                    if (w_enter || w_clear) begin
                        r_state        <= ST_ENTRY;
                        r_prog_mode    <= 1'b0;
                        r_unlocked     <= 1'b0;
                        r_entry_enable <= 1'b0;
                        if (w_enter && w_count_ok) begin
                            r_code <= typed;
                        end else if (w_enter) begin
                            r_fail_pulse <= 1'b1;
                        end
                    end else begin
                        r_entry_enable <= 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state        <= ST_ENTRY;
                        r_lockout      <= 1'b0;
                        r_attempts     <= L_MAX_ATTEMPTS;
                        r_entry_enable <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 28'd1;
                    end
                end

                default: begin
                    r_state        <= ST_ENTRY;
                    r_entry_enable <= 1'b0;
                    r_unlocked     <= 1'b0;
                    r_lockout      <= 1'b0;
                    r_prog_mode    <= 1'b0;
                end
            endcase
        end
    end

    assign entry_enable  = r_entry_enable;
    assign unlocked      = r_unlocked;
    assign lockout       = r_lockout;
    assign fail_pulse    = r_fail_pulse;
    assign attempts_left = r_attempts;
    assign prog_mode     = r_prog_mode;

endmodule
